seq_1011_tx: RTL and testbench
==============================

SEQ_1011_TX -- requirements
Module: seq_1011_tx

Interface
REQ-001 Parameter PATTERN, default 4'b1011: bit pattern transmitted, MSB first.
REQ-002 Parameter GAP, default 1, range 0..7: idle cycles (valid=0) after every transmitted bit.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low (rst=0 resets on posedge clk).
REQ-005 start  input  1  request to transmit; sampled only in IDLE.
REQ-006 num_rep  input  4  number of back-to-back pattern copies; sampled with start.
REQ-007 abort  input  1  terminate the current transmission.
REQ-008 valid  output  1  data_out is a qualified serial bit this cycle.
REQ-009 data_out  output  1  serial bit; 0 whenever valid=0.
REQ-010 busy  output  1  transmission in progress.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 tx_count  output  16  completed patterns since reset.

Function
REQ-013 FSM states: IDLE, SEND, GAP, DONE; all outputs registered.
REQ-014 IDLE: start=1, num_rep!=0 and abort=0 sampled at edge N -> SEND; first valid bit (PATTERN[3]) in cycle N+1.
REQ-015 IDLE: start=1 with num_rep=0 -> DONE directly; no valid cycles; done pulses in cycle N+1.
REQ-016 SEND: valid=1 for exactly one cycle per bit; data_out=PATTERN[bit_idx]; bit_idx counts 3 down to 0.
REQ-017 SEND -> GAP when GAP>0; GAP holds valid=0, data_out=0 for exactly GAP cycles, then SEND for the next bit.
REQ-018 GAP=0: bits are emitted on consecutive cycles, with no idle cycle between bits or between copies.
REQ-019 After bit 0: if copies remain, next bit is PATTERN[3] of the next copy (after the gap); otherwise -> DONE, after the trailing gap when GAP>0.
REQ-020 DONE lasts one cycle: done=1, busy=0, then IDLE.
REQ-021 busy=1 in SEND and GAP only.
REQ-022 tx_count increments by 1 in the cycle after bit 0 of each copy is sent; it wraps 16'hFFFF -> 0.
REQ-023 start in SEND/GAP/DONE is ignored; num_rep changes after sampling are ignored.
REQ-024 abort=1 in SEND or GAP -> IDLE next cycle; valid=0, busy=0; no done pulse; tx_count is not incremented for the partial copy.
REQ-025 abort=1 and start=1 together in IDLE: abort wins and no transmission starts.
REQ-026 Output stream is non-overlapping: N copies produce exactly N detections at a non-overlapping 1011 detector.

Reset
REQ-027 rst=0 at a posedge: state=IDLE; valid=0, data_out=0, busy=0, done=0, tx_count=0; all counters are cleared.
REQ-028 Reset mid-transmission takes priority over all inputs; no done pulse; transmission is not resumed after reset.
REQ-029 rst=0 is held: outputs stay at reset values; start is ignored until the first edge with rst=1.

Structure
REQ-030 A shared package holds the state encoding (one-hot, 4 bits), PATTERN_W=4 and the default PATTERN constant; the 1011 detector uses the same package.
REQ-031 A single sub-module, seq_tx_cnt, provides the loadable bit-index, gap and repeat down-counters; the FSM stays in seq_1011_tx.

Verification
REQ-032 GAP=1, num_rep=1, start at edge N -> valid at N+1, N+3, N+5, N+7 with data 1,0,1,1; done at N+9; tx_count=1.
REQ-033 GAP=0, num_rep=3 -> 12 consecutive valid cycles N+1..N+12 carrying 101110111011; done at N+13; tx_count=3.
REQ-034 num_rep=0 -> no valid cycles; done at N+1; tx_count unchanged.
REQ-035 GAP=1, num_rep=2, abort during copy 2 bit 1 -> valid=0 and busy=0 next cycle; no done; tx_count=1.
REQ-036 rst=0 during SEND -> all outputs at reset values at the next edge; start issued 2 cycles after release restarts cleanly with first bit PATTERN[3].
REQ-037 Loopback into the 1011 non-overlapping detector, 500 random num_rep (1..15) runs -> detector count equals the sum of num_rep, which equals tx_count.

Source files
------------

// File: rtl/seq_1011_tx_pkg.sv
// Shared definitions for the 1011 serial transmitter and its loopback detector.
package seq_1011_tx_pkg;

    localparam int PATTERN_W = 4;
    localparam logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1011;

    localparam int BIT_W = $clog2(PATTERN_W);
    localparam int GAP_W = 3;
    localparam int REP_W = 4;
    localparam int CNT_W = 16;

    // One-hot state encoding.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_SEND = 4'b0010,
        S_GAP  = 4'b0100,
        S_DONE = 4'b1000
    } state_e;

endpackage

// File: rtl/seq_1011_tx_cnt.sv
// Loadable down-counters for the transmitter: bit index, gap length, copies left.
module seq_tx_cnt
    import seq_1011_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_load_i,
    input  logic             bit_dec_i,
    input  logic             gap_load_i,
    input  logic [GAP_W-1:0] gap_val_i,
    input  logic             gap_dec_i,
    input  logic             rep_load_i,
    input  logic [REP_W-1:0] rep_val_i,
    input  logic             rep_dec_i,
    output logic [BIT_W-1:0] bit_idx_o,
    output logic [GAP_W-1:0] gap_cnt_o,
    output logic [REP_W-1:0] rep_cnt_o
);

    logic [BIT_W-1:0] bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [REP_W-1:0] rep_q, rep_d;

    // Next counter values; load wins over decrement. The bit index wraps
    // from 0 back to MSB so the next copy starts at the top bit.
    always_comb begin
        bit_d = bit_q;
        gap_d = gap_q;
        rep_d = rep_q;
        if (bit_load_i)     bit_d = BIT_W'(PATTERN_W - 1);
        else if (bit_dec_i) bit_d = bit_q - BIT_W'(1);
        if (gap_load_i)     gap_d = gap_val_i;
        else if (gap_dec_i) gap_d = gap_q - GAP_W'(1);
        if (rep_load_i)     rep_d = rep_val_i;
        else if (rep_dec_i) rep_d = rep_q - REP_W'(1);
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_q <= '0;
            gap_q <= '0;
            rep_q <= '0;
        end else begin
            bit_q <= bit_d;
            gap_q <= gap_d;
            rep_q <= rep_d;
        end
    end

    assign bit_idx_o = bit_q;
    assign gap_cnt_o = gap_q;
    assign rep_cnt_o = rep_q;

endmodule

// File: rtl/seq_1011_tx.sv
// Serial pattern transmitter: sends num_rep copies of PATTERN MSB first,
// with GAP idle cycles after every bit. All outputs are registered.
module seq_1011_tx
    import seq_1011_tx_pkg::*;
#(
    parameter logic [PATTERN_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int unsigned          GAP     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] num_rep,
    input  logic             abort,
    output logic             valid,
    output logic             data_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_count,
    output logic [3:0]       state_dbg
);

    // Handshake: start is a level request accepted only in IDLE together with
    // num_rep; there is no back-pressure, valid qualifies data_out for one cycle.

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;

    logic             bit_load, bit_dec, gap_load, gap_dec, rep_load, rep_dec;
    logic [BIT_W-1:0] bit_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [REP_W-1:0] rep_cnt;

    seq_tx_cnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .bit_load_i (bit_load),
        .bit_dec_i  (bit_dec),
        .gap_load_i (gap_load),
        .gap_val_i  (GAP_W'(GAP)),
        .gap_dec_i  (gap_dec),
        .rep_load_i (rep_load),
        .rep_val_i  (num_rep),
        .rep_dec_i  (rep_dec),
        .bit_idx_o  (bit_idx),
        .gap_cnt_o  (gap_cnt),
        .rep_cnt_o  (rep_cnt)
    );

    // Next state, counter controls and next output values. Outputs describe
    // the state being entered, so they line up with state_q after the edge.
    always_comb begin
        state_d    = state_q;
        data_d     = 1'b0;
        tx_count_d = tx_count_q;
        bit_load   = 1'b0;
        bit_dec    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        rep_load   = 1'b0;
        rep_dec    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (num_rep != '0) begin
                        state_d  = S_SEND;
                        bit_load = 1'b1;
                        rep_load = 1'b1;
                        data_d   = PATTERN[PATTERN_W-1];
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    bit_dec = 1'b1;
                    if (bit_idx == '0) begin
                        rep_dec    = 1'b1;
                        tx_count_d = tx_count_q + CNT_W'(1);
                    end
                    if (GAP != 0) begin
                        state_d  = S_GAP;
                        gap_load = 1'b1;
                    end else if (bit_idx == '0 && rep_cnt == REP_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        data_d = PATTERN[bit_idx - BIT_W'(1)];
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_cnt == GAP_W'(1)) begin
                    // Copies-left reaches zero only after the final bit 0.
                    if (rep_cnt == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEND;
                        data_d  = PATTERN[bit_idx];
                    end
                end else begin
                    gap_dec = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_SEND);
        busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

    // State and registered outputs; reset overrides every input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            data_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign valid     = valid_q;
    assign data_out  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_count  = tx_count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_1011_tx.sv
// Bench for seq_1011_tx: one instance with GAP=0 and one with GAP=1,
// checked cycle by cycle against a stream model and a loopback detector.
module tb_seq_1011_tx;
    import seq_1011_tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start[2];
    logic [3:0]  num_rep[2];
    logic        abort[2];
    logic        valid[2];
    logic        data_out[2];
    logic        busy[2];
    logic        done[2];
    logic [15:0] tx_count[2];
    logic [3:0]  state_dbg[2];

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_cnt[2];
    logic [3:0]  pat = DEFAULT_PATTERN;

    always #5 clk = ~clk;

    seq_1011_tx #(.GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .start(start[0]), .num_rep(num_rep[0]), .abort(abort[0]),
        .valid(valid[0]), .data_out(data_out[0]), .busy(busy[0]), .done(done[0]),
        .tx_count(tx_count[0]), .state_dbg(state_dbg[0])
    );

    seq_1011_tx #(.GAP(1)) dut_g1 (
        .clk(clk), .rst(rst), .start(start[1]), .num_rep(num_rep[1]), .abort(abort[1]),
        .valid(valid[1]), .data_out(data_out[1]), .busy(busy[1]), .done(done[1]),
        .tx_count(tx_count[1]), .state_dbg(state_dbg[1])
    );

    // Non-overlapping 1011 detector on each valid-qualified stream.
    for (genvar gi = 0; gi < 2; gi++) begin : g_det
        logic [3:0] win;
        int         nbits;
        int         cnt;
        always @(posedge clk) begin
            if (!rst) begin
                win <= '0; nbits <= 0; cnt <= 0;
            end else if (valid[gi]) begin
                if (nbits >= 3 && {win[2:0], data_out[gi]} == DEFAULT_PATTERN) begin
                    cnt <= cnt + 1; nbits <= 0; win <= '0;
                end else begin
                    win <= {win[2:0], data_out[gi]};
                    nbits <= (nbits >= 3) ? 3 : nbits + 1;
                end
            end
        end
    end

    function automatic logic [3:0] obs(input int g);
        return {valid[g], data_out[g], busy[g], done[g]};
    endfunction

    // Start one transmission on instance g (gap = g) and check every cycle
    // up to and including done, plus one idle cycle afterwards.
    task automatic run_tx(input int g, input logic [3:0] n, input bit noise);
        logic [3:0] exp_q[$];
        logic [3:0] e, got;
        int         cyc;
        exp_q = {};
        for (int c = 0; c < int'(n); c++) begin
            for (int b = PATTERN_W - 1; b >= 0; b--) begin
                exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0});
                for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0001);
        @(negedge clk);
        start[g] = 1'b1;
        num_rep[g] = n;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = exp_q.pop_front();
            got = obs(g);
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL stream g=%0d n=%0d cyc=%0d got=%b exp=%b", g, n, cyc, got, e);
            end
            start[g] = (noise && exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) num_rep[g] = 4'($urandom);
        end
        exp_cnt[g] = exp_cnt[g] + 16'(n);
        @(negedge clk);
        tests_run++;
        if (obs(g) !== 4'b0000 || tx_count[g] !== exp_cnt[g]) begin
            tests_failed++;
            $display("FAIL after_run g=%0d outs=%b cnt=%0d exp_outs=0000 exp_cnt=%0d",
                     g, obs(g), tx_count[g], exp_cnt[g]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b1; num_rep[g] = 4'd3; abort[g] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                tests_run++;
                if (obs(g) !== 4'b0000 || tx_count[g] !== 16'd0) begin
                    tests_failed++;
                    $display("FAIL reset_hold g=%0d outs=%b cnt=%0d exp=0000/0", g, obs(g), tx_count[g]);
                end
            end
        end
        start[0] = 1'b0; start[1] = 1'b0;
        rst = 1'b1;
        exp_cnt[0] = '0; exp_cnt[1] = '0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_tx(1, 4'd1, 1'b0);
        run_tx(0, 4'd3, 1'b0);
        run_tx(1, 4'd2, 1'b0);
        run_tx(0, 4'd1, 1'b0);
    endtask

    task automatic test_zero_rep;
        run_tx(0, 4'd0, 1'b0);
        run_tx(1, 4'd0, 1'b0);
    endtask

    task automatic test_ignore_inputs;
        run_tx(1, 4'd3, 1'b1);
        run_tx(0, 4'd4, 1'b1);
    endtask

    task automatic test_abort_start;
        @(negedge clk);
        start[1] = 1'b1; abort[1] = 1'b1; num_rep[1] = 4'd2;
        @(negedge clk);
        start[1] = 1'b0; abort[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (obs(1) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL abort_with_start cyc=%0d outs=%b exp=0000", c, obs(1));
            end
            @(negedge clk);
        end
    endtask

    // GAP=1, 2 copies, abort while copy 2 bit 1 is on the line.
    task automatic test_abort;
        int abort_cyc;
        logic [3:0] e;
        abort_cyc = (1 * PATTERN_W + 2) * 2 + 1;
        @(negedge clk);
        start[1] = 1'b1; num_rep[1] = 4'd2;
        for (int c = 1; c <= abort_cyc; c++) begin
            @(negedge clk);
            start[1] = 1'b0;
            if (c % 2 == 1) e = {1'b1, pat[PATTERN_W - 1 - ((c - 1) / 2) % PATTERN_W], 2'b10};
            else            e = 4'b0010;
            tests_run++;
            if (obs(1) !== e) begin
                tests_failed++;
                $display("FAIL abort_pre cyc=%0d got=%b exp=%b", c, obs(1), e);
            end
            if (c == abort_cyc) abort[1] = 1'b1;
        end
        @(negedge clk);
        abort[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (obs(1) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL abort_post cyc=%0d outs=%b exp=0000", c, obs(1));
            end
            @(negedge clk);
        end
        exp_cnt[1] = exp_cnt[1] + 16'd1;
        tests_run++;
        if (tx_count[1] !== exp_cnt[1]) begin
            tests_failed++;
            $display("FAIL abort_count got=%0d exp=%0d", tx_count[1], exp_cnt[1]);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start[1] = 1'b1; num_rep[1] = 4'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start[1] = 1'b0;
        end
        tests_run++;
        if (busy[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_busy got=%b exp=1", busy[1]);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            tests_run++;
            if (obs(g) !== 4'b0000 || tx_count[g] !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_mid g=%0d outs=%b cnt=%0d exp=0000/0", g, obs(g), tx_count[g]);
            end
        end
        rst = 1'b1;
        exp_cnt[0] = '0; exp_cnt[1] = '0;
        @(negedge clk);
        tests_run++;
        if (obs(1) !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_no_resume outs=%b exp=0000", obs(1));
        end
        run_tx(1, 4'd1, 1'b0);
    endtask

    task automatic test_loopback;
        int sum[2];
        int g;
        logic [3:0] n;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt[0] = '0; exp_cnt[1] = '0;
        sum[0] = 0; sum[1] = 0;
        for (int r = 0; r < 500; r++) begin
            g = r % 2;
            n = 4'($urandom_range(1, 15));
            run_tx(g, n, ($urandom_range(0, 3) == 0));
            sum[g] += int'(n);
        end
        @(negedge clk);
        tests_run++;
        if (g_det[0].cnt !== sum[0] || int'(tx_count[0]) !== sum[0]) begin
            tests_failed++;
            $display("FAIL loopback g=0 det=%0d cnt=%0d exp=%0d", g_det[0].cnt, tx_count[0], sum[0]);
        end
        tests_run++;
        if (g_det[1].cnt !== sum[1] || int'(tx_count[1]) !== sum[1]) begin
            tests_failed++;
            $display("FAIL loopback g=1 det=%0d cnt=%0d exp=%0d", g_det[1].cnt, tx_count[1], sum[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_rep();
        test_ignore_inputs();
        test_abort_start();
        test_abort();
        test_reset_mid();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
